atm_account_arbiter: RTL

- Shares one account-balance register between NUM_TERM ATM session controllers. Each terminal raises a request carrying an operation and an amount.
- A round-robin arbiter grants one terminal at a time. The block executes the balance query, withdrawal or deposit atomically and returns the result with a one-cycle response pulse.
- It sits between the per-terminal session FSMs and the shared balance store, and replaces the private balance register each session would otherwise hold.

---
 rtl/atm_account_arbiter_pkg.sv | 20 ++
 rtl/atm_account_arbiter_if.sv | 28 ++
 rtl/atm_account_arbiter_rr_arbiter.sv | 37 +++
 rtl/atm_account_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/atm_account_arbiter_pkg.sv
// Shared types and defaults for the ATM account arbiter.
// Holds the op encodings, the arbiter state enum and the reset balance.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_INVALID  = 2'b00,
    OP_QUERY    = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_DEPOSIT  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int INIT_BAL_DEFAULT = 1000;

endpackage

// File: rtl/atm_account_arbiter_if.sv
// Terminal-side bundle of the account arbiter.
// The master modport belongs to the terminals and the slave modport to the arbiter.
interface atm_account_arbiter_if #(
  parameter int NUM_TERM = 4,
  parameter int BAL_W    = 16
);
  logic [NUM_TERM-1:0]       req;
  logic [2*NUM_TERM-1:0]     op;
  logic [BAL_W*NUM_TERM-1:0] amount;
  logic [NUM_TERM-1:0]       unlock;
  logic [NUM_TERM-1:0]       grant;
  logic                      resp_valid;
  logic                      resp_ok;
  logic                      resp_insufficient;
  logic [BAL_W-1:0]          resp_balance;
  logic [NUM_TERM-1:0]       locked;
  logic                      busy;

  modport master (
    output req, op, amount, unlock,
    input  grant, resp_valid, resp_ok, resp_insufficient, resp_balance, locked, busy
  );

  modport slave (
    input  req, op, amount, unlock,
    output grant, resp_valid, resp_ok, resp_insufficient, resp_balance, locked, busy
  );
endinterface

// File: rtl/atm_account_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible terminal at or above rr_ptr,
// wrapping at NUM_TERM-1 back to 0.
module rr_arbiter #(
  parameter int NUM_TERM = 4,
  parameter int PTR_W    = $clog2(NUM_TERM)
) (
  input  logic [NUM_TERM-1:0] eligible,
  input  logic [PTR_W-1:0]    rr_ptr,
  output logic [NUM_TERM-1:0] winner,
  output logic [PTR_W-1:0]    winner_idx,
  output logic                any
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_TERM; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_TERM)) begin
        sum = sum - (PTR_W+1)'(NUM_TERM);
      end
      idx = sum[PTR_W-1:0];
      if (!any && eligible[idx]) begin
        any         = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Shared account balance with round-robin access from NUM_TERM terminals.
// Each granted operation runs IDLE -> EXEC -> RESP and commits atomically.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_TERM   = 4,
  parameter int BAL_W      = 16,
  parameter int INIT_BAL   = INIT_BAL_DEFAULT,
  parameter int FAIL_LIMIT = 3
) (
  input logic clk,
  input logic reset,
  atm_account_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_TERM);
  localparam int CNT_W = $clog2(FAIL_LIMIT + 1);

  arb_state_t          state_reg;
  logic [PTR_W-1:0]    rr_ptr_reg;
  logic [NUM_TERM-1:0] grant_reg;
  op_t                 op_reg;
  logic [BAL_W-1:0]    amount_reg;
  logic [BAL_W-1:0]    balance_reg;
  logic                resp_valid_reg;
  logic                resp_ok_reg;
  logic                resp_insufficient_reg;
  logic [BAL_W-1:0]    resp_balance_reg;

  logic [NUM_TERM-1:0] locked;
  logic [NUM_TERM-1:0] eligible;
  logic [NUM_TERM-1:0] win_onehot;
  logic [PTR_W-1:0]    win_idx;
  logic                win_any;
  logic [PTR_W-1:0]    ptr_next;

  logic [1:0]       op_arr  [NUM_TERM];
  logic [BAL_W-1:0] amt_arr [NUM_TERM];

  logic [BAL_W:0]   dep_sum;
  logic [BAL_W-1:0] balance_next;
  logic             ok_next;
  logic             insufficient_next;

  assign eligible = bus.req & ~locked;

  rr_arbiter #(.NUM_TERM(NUM_TERM), .PTR_W(PTR_W)) u_rr (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr_reg),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  assign ptr_next = (win_idx == PTR_W'(NUM_TERM - 1)) ? '0 : win_idx + PTR_W'(1);

  // Operation result, committed at the edge leaving EXEC.
  always_comb begin
    balance_next      = balance_reg;
    ok_next           = 1'b0;
    insufficient_next = 1'b0;
    dep_sum           = {1'b0, balance_reg} + {1'b0, amount_reg};
    case (op_reg)
      OP_QUERY: ok_next = 1'b1;
      OP_WITHDRAW: begin
        if (amount_reg <= balance_reg) begin
          balance_next = balance_reg - amount_reg;
          ok_next      = 1'b1;
        end else begin
          insufficient_next = 1'b1;
        end
      end
      OP_DEPOSIT: begin
        balance_next = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
        ok_next      = 1'b1;
      end
      default: ok_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg             <= IDLE;
      rr_ptr_reg            <= '0;
      grant_reg             <= '0;
      op_reg                <= OP_INVALID;
      amount_reg            <= '0;
      balance_reg           <= BAL_W'(INIT_BAL);
      resp_valid_reg        <= 1'b0;
      resp_ok_reg           <= 1'b0;
      resp_insufficient_reg <= 1'b0;
      resp_balance_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          resp_valid_reg        <= 1'b0;
          resp_ok_reg           <= 1'b0;
          resp_insufficient_reg <= 1'b0;
          resp_balance_reg      <= '0;
          if (win_any) begin
            op_reg     <= op_t'(op_arr[win_idx]);
            amount_reg <= amt_arr[win_idx];
            grant_reg  <= win_onehot;
            rr_ptr_reg <= ptr_next;
            state_reg  <= EXEC;
          end else begin
            grant_reg <= '0;
          end
        end
        EXEC: begin
          balance_reg           <= balance_next;
          resp_valid_reg        <= 1'b1;
          resp_ok_reg           <= ok_next;
          resp_insufficient_reg <= insufficient_next;
          resp_balance_reg      <= balance_next;
          state_reg             <= RESP;
        end
        RESP: begin
          grant_reg             <= '0;
          resp_valid_reg        <= 1'b0;
          resp_ok_reg           <= 1'b0;
          resp_insufficient_reg <= 1'b0;
          resp_balance_reg      <= '0;
          state_reg             <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-terminal unpacking, fail counting and lockout; unlock overrides a same-edge failure.
  for (genvar gi = 0; gi < NUM_TERM; gi++) begin : g_term
    logic [CNT_W-1:0] fail_cnt_reg;
    logic [CNT_W-1:0] fail_cnt_inc;
    logic             lock_reg;

    assign op_arr[gi]   = bus.op[2*gi +: 2];
    assign amt_arr[gi]  = bus.amount[BAL_W*gi +: BAL_W];
    assign fail_cnt_inc = fail_cnt_reg + CNT_W'(1);
    assign locked[gi]   = lock_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        fail_cnt_reg <= '0;
        lock_reg     <= 1'b0;
      end else if (bus.unlock[gi]) begin
        fail_cnt_reg <= '0;
        lock_reg     <= 1'b0;
      end else if (state_reg == RESP && grant_reg[gi]) begin
        if (resp_ok_reg) begin
          fail_cnt_reg <= '0;
        end else begin
          fail_cnt_reg <= fail_cnt_inc;
          if (fail_cnt_inc >= CNT_W'(FAIL_LIMIT)) begin
            lock_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.grant             = grant_reg;
  assign bus.resp_valid        = resp_valid_reg;
  assign bus.resp_ok           = resp_ok_reg;
  assign bus.resp_insufficient = resp_insufficient_reg;
  assign bus.resp_balance      = resp_balance_reg;
  assign bus.locked            = locked;
  assign bus.busy              = (state_reg != IDLE);

endmodule
